// File: rtl/team_06_echo_delay_ctrl.sv
// Echo-path sequencer: per accepted sample, reads the delayed sample from the delay-line SRAM,
// hands it to the echo datapath, then writes the datapath result back at the write pointer.
module team_06_echo_delay_ctrl #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic              echo_en,
    input  logic [ADDR_W-1:0] delay,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              search_enable,
    output logic [DATA_W-1:0] past_output,
    input  logic [DATA_W-1:0] save_audio,
    output logic              sample_done,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        MIX,
        WR_REQ,
        WR_WAIT
    } state_t;

    state_t            r_state, w_stateNext;
    logic [ADDR_W-1:0] r_wrPtr, w_wrPtrNext;
    logic [ADDR_W-1:0] r_fill, w_fillNext;
    logic [ADDR_W-1:0] r_addr, w_addrNext;
    logic              r_rd, w_rdNext;
    logic              r_wr, w_wrNext;
    logic [DATA_W-1:0] r_wdata, w_wdataNext;
    logic              r_search, w_searchNext;
    logic [DATA_W-1:0] r_past, w_pastNext;
    logic              r_done, w_doneNext;
    logic              r_overrun, w_overrunNext;
    logic [ADDR_W-1:0] w_rdAddr;
    logic              w_skipRead;

    // Address arithmetic wraps naturally at 2**ADDR_W.
    assign w_rdAddr   = r_wrPtr - delay;
    assign w_skipRead = !echo_en || (delay == '0) || (r_fill < delay);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_wrPtr   <= '0;
            r_fill    <= '0;
            r_addr    <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_wdata   <= '0;
            r_search  <= 1'b0;
            r_past    <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_wrPtr   <= w_wrPtrNext;
            r_fill    <= w_fillNext;
            r_addr    <= w_addrNext;
            r_rd      <= w_rdNext;
            r_wr      <= w_wrNext;
            r_wdata   <= w_wdataNext;
            r_search  <= w_searchNext;
            r_past    <= w_pastNext;
            r_done    <= w_doneNext;
            r_overrun <= w_overrunNext;
        end
    end

    // Requests are raised on entry to RD_REQ/WR_REQ so the address is already stable when seen.
    always_comb begin
        w_stateNext   = r_state;
        w_wrPtrNext   = r_wrPtr;
        w_fillNext    = r_fill;
        w_addrNext    = r_addr;
        w_rdNext      = r_rd;
        w_wrNext      = r_wr;
        w_wdataNext   = r_wdata;
        w_searchNext  = r_search;
        w_pastNext    = r_past;
        w_doneNext    = 1'b0;
        w_overrunNext = r_overrun;

        if (sample_valid && (r_state != IDLE)) begin
            w_overrunNext = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (sample_valid) begin
                    if (w_skipRead) begin
                        w_pastNext   = '0;
                        w_searchNext = 1'b0;
                        w_stateNext  = MIX;
                    end else begin
                        w_addrNext  = w_rdAddr;
                        w_rdNext    = 1'b1;
                        w_stateNext = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                w_stateNext = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_ack) begin
                    w_pastNext   = mem_rdata;
                    w_searchNext = 1'b1;
                    w_rdNext     = 1'b0;
                    w_stateNext  = MIX;
                end
            end
            MIX: begin
                w_wdataNext = save_audio;
                w_addrNext  = r_wrPtr;
                w_wrNext    = 1'b1;
                w_stateNext = WR_REQ;
            end
            WR_REQ: begin
                w_stateNext = WR_WAIT;
            end
            WR_WAIT: begin
                if (mem_ack) begin
                    w_wrNext     = 1'b0;
                    w_doneNext   = 1'b1;
                    w_wrPtrNext  = r_wrPtr + ADDR_W'(1);
                    w_fillNext   = (r_fill == '1) ? r_fill : r_fill + ADDR_W'(1);
                    w_searchNext = 1'b0;
                    w_stateNext  = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign mem_addr      = r_addr;
    assign mem_rd        = r_rd;
    assign mem_wr        = r_wr;
    assign mem_wdata     = r_wdata;
    assign search_enable = r_search;
    assign past_output   = r_past;
    assign sample_done   = r_done;
    assign overrun       = r_overrun;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_team_06_echo_delay_ctrl.sv
// Scoreboard bench for team_06_echo_delay_ctrl: a behavioural SRAM with programmable ack latency,
// a reference model that queues the expected write-back per sample, and a monitor that checks it.
module tb_team_06_echo_delay_ctrl;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sample_valid = 1'b0;
    logic              echo_en = 1'b0;
    logic [ADDR_W-1:0] delay = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack;
    logic              search_enable;
    logic [DATA_W-1:0] past_output;
    logic [DATA_W-1:0] save_audio = '0;
    logic              sample_done;
    logic              busy;
    logic              overrun;

    team_06_echo_delay_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .echo_en(echo_en), .delay(delay),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .search_enable(search_enable),
        .past_output(past_output), .save_audio(save_audio), .sample_done(sample_done),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] past;
        logic              search;
    } exp_t;

    exp_t sbQ[$];
    int testsRun = 0;
    int testsFailed = 0;

    logic [DATA_W-1:0] sram     [DEPTH];
    logic [DATA_W-1:0] modelMem [DEPTH];
    int modelPtr = 0;
    int modelFill = 0;

    // ackLat counts request-visible edges before ack; 1 means ack the cycle after the request.
    int   ackLat = 1;
    int   ackCnt = 0;
    logic memAck = 1'b0;
    logic injAck = 1'b0;
    assign mem_ack = memAck | injAck;

    always @(posedge clk) begin
        if (mem_ack) begin
            memAck <= 1'b0;
            ackCnt <= 0;
        end else if (mem_rd || mem_wr) begin
            if (ackCnt + 1 >= ackLat) begin
                memAck <= 1'b1;
                if (mem_wr) sram[mem_addr] <= mem_wdata;
                else mem_rdata <= sram[mem_addr];
            end else begin
                ackCnt <= ackCnt + 1;
            end
        end else begin
            ackCnt <= 0;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    bit                reqActive = 1'b0;
    logic [ADDR_W-1:0] reqAddr = '0;
    int holdCnt = 0;
    int lastRdHold = 0;
    int rdCount = 0;
    int lastRdAddr = -1;
    int lastWrAddr = -1;

    always @(negedge clk) begin
        if (mem_rd || mem_wr) begin
            if (!reqActive) begin
                reqActive = 1'b1;
                reqAddr   = mem_addr;
                holdCnt   = 0;
                if (mem_rd) rdCount++;
            end
            holdCnt++;
            if (mem_ack) begin
                checkOutput("rdWrExclusive", int'(mem_rd & mem_wr), 0);
                checkOutput("reqAddrStable", int'(mem_addr), int'(reqAddr));
                if (mem_rd) begin
                    lastRdHold = holdCnt;
                    lastRdAddr = int'(mem_addr);
                end else begin
                    lastWrAddr = int'(mem_addr);
                    if (sbQ.size() == 0) begin
                        testsRun++;
                        testsFailed++;
                        $display("[TB] FAIL unexpectedWrite: got addr %0d, expected no write", mem_addr);
                    end else begin
                        exp_t e;
                        e = sbQ.pop_front();
                        checkOutput("wrAddr", int'(mem_addr), int'(e.addr));
                        checkOutput("wrData", int'(mem_wdata), int'(e.data));
                        checkOutput("pastOutput", int'(past_output), int'(e.past));
                        checkOutput("searchEnable", int'(search_enable), int'(e.search));
                    end
                end
                reqActive = 1'b0;
            end
        end else begin
            reqActive = 1'b0;
        end
    end

    // Model the expected write-back, then issue the sample and wait (bounded) for sample_done.
    task automatic applyStimulus(input logic [DATA_W-1:0] data, input int dly, input logic en,
                                 input int expLat, input bit dup);
        exp_t e;
        bit   skip;
        int   cnt;
        bit   seen;
        skip     = !en || (dly == 0) || (modelFill < dly);
        e.addr   = ADDR_W'(modelPtr);
        e.data   = data;
        e.search = !skip;
        e.past   = skip ? '0 : modelMem[(modelPtr - dly + DEPTH) % DEPTH];
        sbQ.push_back(e);
        modelMem[modelPtr] = data;
        modelPtr  = (modelPtr + 1) % DEPTH;
        modelFill = (modelFill < DEPTH - 1) ? modelFill + 1 : modelFill;

        save_audio   = data;
        delay        = ADDR_W'(dly);
        echo_en      = en;
        sample_valid = 1'b1;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 200) begin
            @(negedge clk);
            cnt++;
            seen = sample_done;
            if (cnt == 1) sample_valid = 1'b0;
            if (dup && cnt == 2) sample_valid = 1'b1;
            if (dup && cnt == 3) sample_valid = 1'b0;
        end
        sample_valid = 1'b0;
        if (!seen) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL sampleDoneTimeout: got no sample_done, expected one within 200 cycles");
        end else if (expLat >= 0) begin
            checkOutput("latency", cnt, expLat);
        end
        @(negedge clk);
    endtask

    initial begin
        int snap;
        int cnt;
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]     = '0;
            modelMem[i] = '0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstMemRd", int'(mem_rd), 0);
        checkOutput("rstMemWr", int'(mem_wr), 0);
        checkOutput("rstMemAddr", int'(mem_addr), 0);
        checkOutput("rstDone", int'(sample_done), 0);
        checkOutput("rstOverrun", int'(overrun), 0);
        checkOutput("rstSearch", int'(search_enable), 0);
        checkOutput("rstPast", int'(past_output), 0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] fill gating: delay 2, samples 10,20,30");
        applyStimulus(8'd10, 2, 1'b1, 4, 1'b0);
        applyStimulus(8'd20, 2, 1'b1, 4, 1'b0);
        applyStimulus(8'd30, 2, 1'b1, 6, 1'b0);
        checkOutput("t1RdAddr", lastRdAddr, 0);
        checkOutput("t1PastHeld", int'(past_output), 10);
        checkOutput("t1SearchCleared", int'(search_enable), 0);

        $display("[TB] pointer wrap: preload to 8190, delay 3");
        for (int i = 3; i < 8190; i++) applyStimulus(DATA_W'(i), 0, 1'b0, -1, 1'b0);
        applyStimulus(8'hA1, 3, 1'b1, 6, 1'b0);
        checkOutput("t2WrAddr8190", lastWrAddr, 8190);
        applyStimulus(8'hB2, 3, 1'b1, 6, 1'b0);
        checkOutput("t2WrAddr8191", lastWrAddr, 8191);
        applyStimulus(8'hC3, 3, 1'b1, 6, 1'b0);
        checkOutput("t2WrAddr0", lastWrAddr, 0);
        checkOutput("t2PastAt0", int'(past_output), 8189 % 256);
        applyStimulus(8'hD4, 3, 1'b1, 6, 1'b0);
        checkOutput("t2WrapRdAddr", lastRdAddr, 8190);
        checkOutput("t2WrapPast", int'(past_output), 8'hA1);

        $display("[TB] bypass: delay 0 and echo_en 0");
        snap = rdCount;
        applyStimulus(8'h11, 0, 1'b1, 4, 1'b0);
        applyStimulus(8'h22, 5, 1'b0, 4, 1'b0);
        checkOutput("t3NoRead", rdCount, snap);
        checkOutput("t3PastZero", int'(past_output), 0);

        $display("[TB] slow SRAM: ack latency 5");
        ackLat = 5;
        applyStimulus(8'h33, 1, 1'b1, 14, 1'b0);
        checkOutput("t4RdHold", lastRdHold, 6);
        checkOutput("t4Past", int'(past_output), 8'h22);
        ackLat = 1;

        $display("[TB] overrun: second strobe 2 cycles after accept");
        checkOutput("t5OverrunBefore", int'(overrun), 0);
        snap = modelPtr;
        applyStimulus(8'h44, 1, 1'b1, 6, 1'b1);
        checkOutput("t5Overrun", int'(overrun), 1);
        checkOutput("t5SingleAdvance", lastWrAddr, snap);
        repeat (10) @(negedge clk);
        checkOutput("t5NoExtraWork", int'(busy), 0);

        $display("[TB] reset during write wait");
        ackLat = 8;
        save_audio   = 8'h55;
        delay        = ADDR_W'(1);
        echo_en      = 1'b0;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        cnt = 0;
        while (!mem_wr && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("t6WrSeen", int'(mem_wr), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t6WrDropped", int'(mem_wr), 0);
        checkOutput("t6Busy", int'(busy), 0);
        checkOutput("t6OverrunCleared", int'(overrun), 0);
        rst = 1'b1;
        modelPtr  = 0;
        modelFill = 0;
        ackLat    = 1;
        injAck    = 1'b1;
        @(negedge clk);
        injAck = 1'b0;
        checkOutput("t6LateAckDone", int'(sample_done), 0);
        checkOutput("t6LateAckBusy", int'(busy), 0);
        applyStimulus(8'h66, 1, 1'b1, 4, 1'b0);
        checkOutput("t6WrPtrZero", lastWrAddr, 0);
        applyStimulus(8'h77, 1, 1'b1, 6, 1'b0);
        checkOutput("t6RdAddr", lastRdAddr, 0);
        checkOutput("t6Past", int'(past_output), 8'h66);

        repeat (4) @(negedge clk);
        checkOutput("sbQueueEmpty", sbQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
